serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 16 +
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three input bits.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: latches operands on start, adds one bit pair per clock LSB first,
// then presents {cout, sum} with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Next-state logic for FSM, shift registers, counter and registered outputs.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // New sum bit enters at the MSB; the whole register shifts right.
                s_sh_d  = WIDTH'({fa_s, s_sh_q} >> 1);
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                if (count_q == LAST) begin
                    sum_d   = WIDTH'({fa_s, s_sh_q} >> 1);
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed tests against a timeline
// model, plus an exhaustive WIDTH=4 run with start held high.
module tb_serial_adder;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted operation keeps busy for W+1 cycles; the result
    // appears, with done, in the last of those cycles.
    int         m_left = 0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_cout = 1'b0;
    logic [7:0] m_sum  = 8'h00;
    logic [8:0] m_res  = 9'h000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_sum  = 8'h00;
            m_cout = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start8) begin
                m_res  = 9'(a8) + 9'(b8) + 9'(cin8);
                m_left = W + 1;
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_left--;
            m_busy = (m_left != 0);
            m_done = (m_left == 1);
            if (m_left == 1) {m_cout, m_sum} = m_res;
        end
    end

    // Cycle-by-cycle comparison of the WIDTH=8 instance against the model.
    always @(negedge clk) begin
        chk("dut8_cycle", 32'({busy8, done8, cout8, sum8}), 32'({m_busy, m_done, m_cout, m_sum}));
    end

    // WIDTH=4 scoreboard: each done pops one expected result; dones are 6 cycles apart.
    logic [4:0] q4[$];
    int         cyc = 0;
    int         last_done = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                chk("r4_unexpected_done", 32'(1), 32'(0));
            end else begin
                chk("r4_result", 32'({cout4, sum4}), 32'(q4.pop_front()));
            end
            if (last_done >= 0) chk("r4_spacing", 32'(cyc - last_done), 32'(6));
            last_done = cyc;
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input string nm);
        int n;
        @(negedge clk);
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb_v; cin8 = ~tc;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(9));
        chk({nm, "_sum"}, 32'(sum8), 32'(es));
        chk({nm, "_cout"}, 32'(cout8), 32'(ec));
        chk({nm, "_model"}, 32'({m_cout, m_sum}), 32'({ec, es}));
    endtask

    task automatic count_dones(input int cycles, input string nm);
        int nd;
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk(nm, 32'(nd), 32'(0));
    endtask

    initial begin
        int n;
        int t;
        rst_n  = 1'b0;
        start8 = 1'($urandom);
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        start4 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

        // Reset state with random inputs applied.
        repeat (2) @(negedge clk);
        chk("rst_outputs_a", 32'({busy8, done8, cout8, sum8}), 32'(0));
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        @(negedge clk);
        chk("rst_outputs_b", 32'({busy8, done8, cout8, sum8}), 32'(0));
        start8 = 1'b0;
        rst_n  = 1'b1;
        count_dones(20, "idle_no_done");

        // Directed additions.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_00_00_c");

        // Start while busy is ignored.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n++;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_ign_latency", 32'(n), 32'(9));
        chk("busy_ign_sum", 32'(sum8), 32'(8'h30));
        count_dones(20, "busy_ign_no_second_done");

        // Reset in the middle of an operation.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({busy8, done8, cout8, sum8}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(20, "rst_mid_no_done");
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "add_01_02");

        // Exhaustive WIDTH=4 with start held high.
        for (int k = 0; k < 512; k++) begin
            t = 0;
            @(negedge clk);
            while (busy4 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) begin
                chk("r4_idle_timeout", 32'(1), 32'(0));
                break;
            end
            a4 = k[3:0]; b4 = k[7:4]; cin4 = k[8];
            start4 = 1'b1;
            q4.push_back(5'(a4) + 5'(b4) + 5'(cin4));
        end
        t = 0;
        while (q4.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        start4 = 1'b0;
        chk("r4_drain", 32'(q4.size()), 32'(0));
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
